// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: receiver FSM state encodings, default frame geometry and the parity
// mismatch helper. Imported by uart_receiver and usable by the transmitter side of the link.
package uart_receiver_pkg;

  // FSM state encodings kept as plain 3-bit constants so existing tooling that decodes the state
  // register numerically keeps working.
  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;
  localparam logic [2:0] StBreak  = 3'd5;

  localparam int unsigned DefDataBits  = 8;
  localparam int unsigned DefOversample = 16;

  // True when the received parity bit disagrees with the configured sense.
  // data_xor is the XOR reduction of the payload bits.
  function automatic logic parity_mismatch(input logic data_xor, input logic par_bit,
                                           input logic odd);
    return (data_xor ^ par_bit) != odd;
  endfunction

endpackage

// File: rtl/uart_receiver_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk   - destination clock
//   reset - asynchronous active-high reset; both flops load RESET_VAL
//   d     - asynchronous input
//   q     - synchronized output (two clk of latency)
module uart_receiver_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// Serial-to-parallel UART receiver. Samples the synchronized line on rx_tick strobes
// (OVERSAMPLE per bit), qualifies the start bit at mid-bit, assembles LSB-first payloads and
// reports parity and framing errors as single-clk pulses.
// Ports:
//   clk           - system clock
//   reset         - asynchronous active-high reset
//   rx_tick       - 1-clk oversampling strobe from the baud generator
//   rx            - serial line, idle high, asynchronous to clk
//   data          - last good payload; held until the next good frame
//   data_valid    - 1-clk pulse when data updates
//   parity_error  - 1-clk pulse alongside data_valid on parity mismatch
//   framing_error - 1-clk pulse when the stop bit is sampled low
//   busy          - high whenever the FSM is not idle
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DefDataBits,
  parameter int unsigned OVERSAMPLE = DefOversample,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 busy
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_BITS + 1);

  localparam logic [TickW-1:0] TickMid  = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

  logic                 rxs;
  logic [2:0]           state_q, state_d;
  logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 data_valid_q, data_valid_d;
  logic                 parity_error_q, parity_error_d;
  logic                 framing_error_q, framing_error_d;

  uart_receiver_sync2 #(
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rxs)
  );

  always_comb begin
    state_d         = state_q;
    tick_cnt_d      = tick_cnt_q;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    par_err_d       = par_err_q;
    data_d          = data_q;
    data_valid_d    = 1'b0;
    parity_error_d  = 1'b0;
    framing_error_d = 1'b0;

    if (rx_tick) begin
      case (state_q)
        StIdle: begin
          if (!rxs) begin
            state_d    = StStart;
            tick_cnt_d = '0;
            par_err_d  = 1'b0;
          end
        end

        StStart: begin
          if (tick_cnt_q == TickMid) begin
            tick_cnt_d = '0;
            if (!rxs) begin
              state_d   = StData;
              bit_cnt_d = '0;
            end else begin
              // Line went back high before mid start bit: treat as a glitch.
              state_d = StIdle;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        StData: begin
          if (tick_cnt_q == TickLast) begin
            shift_d    = {rxs, shift_q[DATA_BITS-1:1]};
            tick_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BitLast) begin
              state_d = PARITY_EN ? StParity : StStop;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        StParity: begin
          if (tick_cnt_q == TickLast) begin
            par_err_d  = parity_mismatch(^shift_q, rxs, PARITY_ODD);
            tick_cnt_d = '0;
            state_d    = StStop;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        StStop: begin
          if (tick_cnt_q == TickLast) begin
            tick_cnt_d = '0;
            if (rxs) begin
              data_d         = shift_q;
              data_valid_d   = 1'b1;
              parity_error_d = par_err_q;
              state_d        = StIdle;
            end else begin
              framing_error_d = 1'b1;
              state_d         = StBreak;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        StBreak: begin
          // Hold off until the line idles so a stuck-low line cannot look like new starts.
          if (rxs) begin
            state_d = StIdle;
          end
        end

        default: begin
          state_d    = StIdle;
          tick_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      tick_cnt_q      <= '0;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      par_err_q       <= 1'b0;
      data_q          <= '0;
      data_valid_q    <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      tick_cnt_q      <= tick_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      par_err_q       <= par_err_d;
      data_q          <= data_d;
      data_valid_q    <= data_valid_d;
      parity_error_q  <= parity_error_d;
      framing_error_q <= framing_error_d;
    end
  end

  assign data          = data_q;
  assign data_valid    = data_valid_q;
  assign parity_error  = parity_error_q;
  assign framing_error = framing_error_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

  localparam int BitClks = 64;  // 16 ticks per bit, one tick every 4 clks

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_tick = 1'b0;
  logic       rx = 1'b1;
  logic       rx_p = 1'b1;

  logic [7:0] data_a, data_b;
  logic       dv_a, pe_a, fe_a, busy_a;
  logic       dv_b, pe_b, fe_b, busy_b;

  exp_t       q_a[$];
  exp_t       q_b[$];
  logic [7:0] last_a = 8'h00;
  logic [7:0] last_b = 8'h00;
  int         tests_run = 0;
  int         tests_failed = 0;

  uart_receiver #(
    .DATA_BITS (8),
    .OVERSAMPLE(16),
    .PARITY_EN (1'b0),
    .PARITY_ODD(1'b0)
  ) dut_a (
    .clk          (clk),
    .reset        (reset),
    .rx_tick      (rx_tick),
    .rx           (rx),
    .data         (data_a),
    .data_valid   (dv_a),
    .parity_error (pe_a),
    .framing_error(fe_a),
    .busy         (busy_a)
  );

  uart_receiver #(
    .DATA_BITS (8),
    .OVERSAMPLE(16),
    .PARITY_EN (1'b1),
    .PARITY_ODD(1'b0)
  ) dut_b (
    .clk          (clk),
    .reset        (reset),
    .rx_tick      (rx_tick),
    .rx           (rx_p),
    .data         (data_b),
    .data_valid   (dv_b),
    .parity_error (pe_b),
    .framing_error(fe_b),
    .busy         (busy_b)
  );

  always #5 clk = ~clk;

  // One-clk tick every 4 clks.
  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #1 rx_tick = 1'b1;
      @(posedge clk);
      #1 rx_tick = 1'b0;
    end
  end

  // Advance one clk and score any output pulse against the expectation queues.
  task automatic step();
    logic       dv, pe, fe;
    logic [7:0] d;
    exp_t       e;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        dv = dv_a; pe = pe_a; fe = fe_a; d = data_a;
      end else begin
        dv = dv_b; pe = pe_b; fe = fe_b; d = data_b;
      end
      if (dv || fe || pe) begin
        tests_run++;
        if ((i == 0 && q_a.size() == 0) || (i == 1 && q_b.size() == 0)) begin
          tests_failed++;
          $display("FAIL sb_unexpected dut%0d: got dv=%b pe=%b fe=%b data=%h, required no pulse",
                   i, dv, pe, fe, d);
        end else begin
          if (i == 0) e = q_a.pop_front();
          else        e = q_b.pop_front();
          if ({dv, pe, fe, d} !== {~e.ferr, e.perr, e.ferr, e.data}) begin
            tests_failed++;
            $display("FAIL sb_result dut%0d: got dv=%b pe=%b fe=%b data=%h, required dv=%b pe=%b fe=%b data=%h",
                     i, dv, pe, fe, d, ~e.ferr, e.perr, e.ferr, e.data);
          end
        end
      end
    end
  endtask

  task automatic drive_bit(input logic sel, input logic v);
    if (sel) rx_p = v;
    else     rx   = v;
    repeat (BitClks) step();
  endtask

  // Push the expected outcome, then serialize start, LSB-first data, optional parity, stop.
  task automatic send_frame(input logic sel, input logic [7:0] b, input logic has_par,
                            input logic par_bit, input logic stop);
    exp_t e;
    e.ferr = ~stop;
    e.perr = stop & has_par & ((^b) ^ par_bit);
    if (sel) e.data = stop ? b : last_b;
    else     e.data = stop ? b : last_a;
    if (stop) begin
      if (sel) last_b = b;
      else     last_a = b;
    end
    if (sel) q_b.push_back(e);
    else     q_a.push_back(e);
    drive_bit(sel, 1'b0);
    for (int k = 0; k < 8; k++) drive_bit(sel, b[k]);
    if (has_par) drive_bit(sel, par_bit);
    drive_bit(sel, stop);
  endtask

  task automatic test_reset();
    repeat (5) step();
    tests_run++;
    if ({data_a, dv_a, pe_a, fe_a, busy_a} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_a: got data=%h dv=%b pe=%b fe=%b busy=%b, required all 0",
               data_a, dv_a, pe_a, fe_a, busy_a);
    end
    tests_run++;
    if ({data_b, dv_b, pe_b, fe_b, busy_b} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_b: got data=%h dv=%b pe=%b fe=%b busy=%b, required all 0",
               data_b, dv_b, pe_b, fe_b, busy_b);
    end
    reset = 1'b0;
    repeat (BitClks) step();
  endtask

  task automatic test_8n1();
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    repeat (BitClks) step();
    tests_run++;
    if (q_a.size() != 0) begin
      tests_failed++;
      $display("FAIL 8n1_pending: got %0d outstanding, required 0", q_a.size());
    end
    tests_run++;
    if (data_a !== 8'hA5 || busy_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL 8n1_state: got data=%h busy=%b, required data=a5 busy=0", data_a, busy_a);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
    repeat (BitClks) step();
    tests_run++;
    if (q_a.size() != 0) begin
      tests_failed++;
      $display("FAIL b2b_pending: got %0d outstanding, required 0", q_a.size());
    end
    tests_run++;
    if (data_a !== 8'hFF) begin
      tests_failed++;
      $display("FAIL b2b_data: got %h, required ff", data_a);
    end
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    repeat (16) step();
    rx = 1'b1;
    repeat (2 * BitClks) step();
    tests_run++;
    if (busy_a !== 1'b0 || data_a !== last_a) begin
      tests_failed++;
      $display("FAIL glitch_state: got busy=%b data=%h, required busy=0 data=%h",
               busy_a, data_a, last_a);
    end
  endtask

  task automatic test_framing();
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (160) step();
    tests_run++;
    if (q_a.size() != 0) begin
      tests_failed++;
      $display("FAIL framing_pending: got %0d outstanding, required 0", q_a.size());
    end
    tests_run++;
    if (busy_a !== 1'b1 || data_a !== 8'hFF) begin
      tests_failed++;
      $display("FAIL framing_hold: got busy=%b data=%h, required busy=1 data=ff", busy_a, data_a);
    end
    rx = 1'b1;
    repeat (32) step();
    tests_run++;
    if (busy_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL framing_release: got busy=%b, required 0", busy_a);
    end
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
    repeat (BitClks) step();
    tests_run++;
    if (q_a.size() != 0 || data_a !== 8'h81) begin
      tests_failed++;
      $display("FAIL framing_next: got pending=%0d data=%h, required pending=0 data=81",
               q_a.size(), data_a);
    end
  endtask

  task automatic test_parity();
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    repeat (BitClks) step();
    tests_run++;
    if (q_b.size() != 0 || data_b !== 8'h07) begin
      tests_failed++;
      $display("FAIL parity_final: got pending=%0d data=%h, required pending=0 data=07",
               q_b.size(), data_b);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    b = 8'h5A;
    drive_bit(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) drive_bit(1'b0, b[k]);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      tests_run++;
      if ({data_a, dv_a, pe_a, fe_a, busy_a} !== 12'h000) begin
        tests_failed++;
        $display("FAIL midreset_outputs: got data=%h dv=%b pe=%b fe=%b busy=%b, required all 0",
                 data_a, dv_a, pe_a, fe_a, busy_a);
      end
    end
    rx = 1'b1;
    last_a = 8'h00;
    last_b = 8'h00;
    reset = 1'b0;
    repeat (BitClks) step();
    send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
    repeat (BitClks) step();
    tests_run++;
    if (q_a.size() != 0 || data_a !== 8'hC3) begin
      tests_failed++;
      $display("FAIL midreset_next: got pending=%0d data=%h, required pending=0 data=c3",
               q_a.size(), data_a);
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_parity();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
